// File: rtl/hq_spi_rab_bridge.sv
// SPI-slave (mode 0, MSB first) to RAB-master bridge: oversamples the SPI pins on sys_clk,
// issues one-cycle register-bus strobes and waits for ack with a watchdog.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | no frame; waits for synced chip select low
// S_CMD    | shifting byte0 {rw, 6'b0, addr[8]}
// S_ADDR   | shifting byte1 addr[7:0]
// S_DATA   | shifting data bytes (write payload or read dummy)
// S_WAIT   | access strobed, waiting for rab_ack or watchdog expiry
module hq_spi_rab_bridge #(
    parameter int RAB_ADDR_WIDTH = 9,
    parameter int RAB_DATA_WIDTH = 8,
    parameter int ACK_TIMEOUT    = 16
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic                      spi_csn,
    input  logic                      spi_sck,
    input  logic                      spi_mosi,
    output logic                      spi_miso,
    output logic                      spi_miso_oe,
    output logic                      rab_write,
    output logic                      rab_read,
    output logic [RAB_ADDR_WIDTH-1:0] rab_addr,
    output logic [RAB_DATA_WIDTH-1:0] rab_wdata,
    input  logic                      rab_ack,
    input  logic [RAB_DATA_WIDTH-1:0] rab_rdata,
    output logic                      rab_timeout
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CMD  = 3'd1;
    localparam logic [2:0] S_ADDR = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_WAIT = 3'd4;

    logic [1:0] csn_sync_q;
    logic [2:0] sck_sync_q;
    logic [1:0] mosi_sync_q;

    logic                      csn_s;
    logic                      mosi_s;
    logic                      sck_rise;
    logic                      sck_fall;

    logic [2:0]                state_q, state_d;
    logic [2:0]                bit_cnt_q, bit_cnt_d;
    logic [6:0]                rx_q, rx_d;
    logic [7:0]                tx_q, tx_d;
    logic                      rw_q, rw_d;
    logic                      addr_hi_q, addr_hi_d;
    logic                      err_q, err_d;
    logic [RAB_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [RAB_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                      rd_q, rd_d;
    logic                      wr_q, wr_d;
    logic [TW-1:0]             tmr_q, tmr_d;

    logic [7:0] rx_byte;
    logic       in_frame;
    logic       byte_done;
    logic       wait_tick;
    logic       timed_out;
    logic       acc_done;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            csn_sync_q  <= 2'b11;
            sck_sync_q  <= 3'b000;
            mosi_sync_q <= 2'b00;
        end else begin
            csn_sync_q  <= {csn_sync_q[0], spi_csn};
            sck_sync_q  <= {sck_sync_q[1:0], spi_sck};
            mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
        end
    end

    assign csn_s    = csn_sync_q[1];
    assign mosi_s   = mosi_sync_q[1];
    assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
    assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];

    assign rx_byte   = {rx_q, mosi_s};
    assign in_frame  = (state_q == S_CMD) || (state_q == S_ADDR) || (state_q == S_DATA);
    assign byte_done = in_frame && !csn_s && sck_rise && (bit_cnt_q == 3'd7);

    // The strobe cycle itself never counts: the register file acks one cycle later.
    assign wait_tick = (state_q == S_WAIT) && !(rd_q || wr_q);
    assign timed_out = wait_tick && !rab_ack && (tmr_q == TW'(1));
    assign acc_done  = wait_tick && (rab_ack || (tmr_q == TW'(1)));

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        rw_d      = rw_q;
        addr_hi_d = addr_hi_q;
        err_d     = err_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_d      = 1'b0;
        wr_d      = 1'b0;
        tmr_d     = tmr_q;

        case (state_q)
            S_IDLE: begin
                if (!csn_s) begin
                    state_d   = S_CMD;
                    bit_cnt_d = 3'd0;
                    tx_d      = {7'b0, err_q};
                end
            end
            S_CMD, S_ADDR, S_DATA: begin
                if (csn_s) begin
                    state_d = S_IDLE;
                end else begin
                    if (sck_rise) begin
                        rx_d      = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                    // A zero bit count means the fall belongs to the previous byte.
                    if (sck_fall && (bit_cnt_q != 3'd0)) begin
                        tx_d = {tx_q[6:0], 1'b0};
                    end
                    if (byte_done) begin
                        tx_d = 8'h00;
                        case (state_q)
                            S_CMD: begin
                                rw_d      = rx_byte[7];
                                addr_hi_d = rx_byte[0];
                                err_d     = 1'b0;
                                state_d   = S_ADDR;
                            end
                            S_ADDR: begin
                                addr_d = RAB_ADDR_WIDTH'({addr_hi_q, rx_byte});
                                if (rw_q) begin
                                    rd_d    = 1'b1;
                                    tmr_d   = TW'(ACK_TIMEOUT);
                                    state_d = S_WAIT;
                                end else begin
                                    state_d = S_DATA;
                                end
                            end
                            default: begin
                                if (rw_q) begin
                                    addr_d = addr_q + RAB_ADDR_WIDTH'(1);
                                    rd_d   = 1'b1;
                                end else begin
                                    wr_d    = 1'b1;
                                    wdata_d = RAB_DATA_WIDTH'(rx_byte);
                                end
                                tmr_d   = TW'(ACK_TIMEOUT);
                                state_d = S_WAIT;
                            end
                        endcase
                    end
                end
            end
            S_WAIT: begin
                if (acc_done) begin
                    if (rw_q) begin
                        tx_d = rab_ack ? 8'(rab_rdata) : 8'h00;
                    end else begin
                        addr_d = addr_q + RAB_ADDR_WIDTH'(1);
                    end
                    if (timed_out) begin
                        err_d = 1'b1;
                    end
                    state_d = csn_s ? S_IDLE : S_DATA;
                end else if (wait_tick) begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= 3'd0;
            rx_q      <= 7'd0;
            tx_q      <= 8'd0;
            rw_q      <= 1'b0;
            addr_hi_q <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            tmr_q     <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            rw_q      <= rw_d;
            addr_hi_q <= addr_hi_d;
            err_q     <= err_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            tmr_q     <= tmr_d;
        end
    end

    assign spi_miso    = tx_q[7];
    assign spi_miso_oe = ~csn_s;
    assign rab_read    = rd_q;
    assign rab_write   = wr_q;
    assign rab_addr    = addr_q;
    assign rab_wdata   = wdata_q;
    assign rab_timeout = timed_out;

endmodule
